// File: rtl/multiplier_pkg.sv
// Shared types and width helpers for the row-serial limb multiplier.
package multiplier_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StFold,
        StNorm,
        StDone
    } state_e;

    // Column width that absorbs NUM_ELEMENTS rows of low and high partial products.
    function automatic int unsigned grid_pp_bit(input int unsigned num_elements,
                                                input int unsigned word_len);
        return word_len + 2 + $clog2(2 * num_elements);
    endfunction

    function automatic int unsigned carry_width(input int unsigned bit_len,
                                                input int unsigned word_len);
        return bit_len - word_len + 1;
    endfunction

endpackage

// File: rtl/multiplier_row_serial_if.sv
// Operand/result handshake bundle of the row-serial multiplier.
interface multiplier_row_serial_if #(
    parameter int unsigned NUM_ELEMENTS = 17,
    parameter int unsigned BIT_LEN      = 17
);
    logic                                   in_valid;
    logic                                   in_ready;
    logic                                   normalize;
    logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]   A;
    logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]   B;
    logic                                   out_valid;
    logic                                   out_ready;
    logic [2*NUM_ELEMENTS-1:0][BIT_LEN-1:0] M;
    logic                                   out_overflow;

    modport master (
        output in_valid, normalize, A, B, out_ready,
        input  in_ready, out_valid, M, out_overflow
    );

    modport slave (
        input  in_valid, normalize, A, B, out_ready,
        output in_ready, out_valid, M, out_overflow
    );
endinterface

// File: rtl/dsp_multiplier.sv
// Single full-width limb product, intended to map onto one DSP block.
module dsp_multiplier #(
    parameter int unsigned BIT_LEN = 17
) (
    input  logic [BIT_LEN-1:0]   a,
    input  logic [BIT_LEN-1:0]   b,
    output logic [2*BIT_LEN-1:0] p
);
    assign p = (2 * BIT_LEN)'(a) * (2 * BIT_LEN)'(b);
endmodule

// File: rtl/multiplier_row_serial.sv
// Row-serial limb multiplier: one B-limb row per cycle into a column accumulator,
// then a carry fold and an optional per-column carry normalisation pass.
module multiplier_row_serial
    import multiplier_pkg::*;
#(
    parameter int unsigned NUM_ELEMENTS = 17,
    parameter int unsigned BIT_LEN      = 17,
    parameter int unsigned WORD_LEN     = 16
) (
    input logic                    clk,
    input logic                    rst,
    multiplier_row_serial_if.slave bus
);
    localparam int unsigned N2   = 2 * NUM_ELEMENTS;
    localparam int unsigned GRID = grid_pp_bit(NUM_ELEMENTS, WORD_LEN);
    localparam int unsigned CW   = carry_width(BIT_LEN, WORD_LEN);
    localparam int unsigned IW   = $clog2(N2);
    localparam int unsigned RW   = $clog2(NUM_ELEMENTS);
    localparam int unsigned PW   = 2 * BIT_LEN;

    state_e                               state_q, state_d;
    logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0] a_q, a_d, b_q, b_d;
    logic                                 norm_q, norm_d;
    logic [N2-1:0][GRID-1:0]              acc_q, acc_d;
    logic [N2-1:0][BIT_LEN-1:0]           m_q, m_d;
    logic [IW-1:0]                        idx_q, idx_d, col;
    logic [CW-1:0]                        carry_q, carry_d;
    logic                                 ovf_q, ovf_d;
    logic [BIT_LEN:0]                     sum;
    logic [NUM_ELEMENTS-1:0][PW-1:0]      prod;
    logic [BIT_LEN-1:0]                   b_row;

    assign b_row = b_q[idx_q[RW-1:0]];

    for (genvar j = 0; j < NUM_ELEMENTS; j++) begin : g_dsp
        dsp_multiplier #(
            .BIT_LEN(BIT_LEN)
        ) u_dsp (
            .a(a_q[j]),
            .b(b_row),
            .p(prod[j])
        );
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        norm_d  = norm_q;
        acc_d   = acc_q;
        m_d     = m_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        col     = '0;
        sum     = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    norm_d  = bus.normalize;
                    acc_d   = '0;
                    idx_d   = '0;
                    carry_d = '0;
                    ovf_d   = 1'b0;
                    state_d = StMul;
                end
            end
            StMul: begin
                // Low half lands in column j+k, high half in column j+k+1.
                for (int j = 0; j < NUM_ELEMENTS; j++) begin
                    col = IW'(j) + idx_q;
                    acc_d[col] = acc_d[col] + GRID'(prod[j][WORD_LEN-1:0]);
                    acc_d[col + IW'(1)] = acc_d[col + IW'(1)] + GRID'(prod[j][PW-1:WORD_LEN]);
                end
                if (idx_q == IW'(NUM_ELEMENTS - 1)) begin
                    idx_d   = '0;
                    state_d = StFold;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            StFold: begin
                m_d[0] = BIT_LEN'(acc_q[0][WORD_LEN-1:0]);
                for (int i = 1; i < N2; i++) begin
                    m_d[i] = BIT_LEN'(GRID'(acc_q[i][WORD_LEN-1:0]) + (acc_q[i-1] >> WORD_LEN));
                end
                idx_d   = '0;
                carry_d = '0;
                ovf_d   = 1'b0;
                state_d = norm_q ? StNorm : StDone;
            end
            StNorm: begin
                sum        = (BIT_LEN + 1)'(m_q[idx_q]) + (BIT_LEN + 1)'(carry_q);
                m_d[idx_q] = BIT_LEN'(sum[WORD_LEN-1:0]);
                carry_d    = CW'(sum >> WORD_LEN);
                if (idx_q == IW'(N2 - 1)) begin
                    ovf_d   = (carry_d != '0);
                    idx_d   = '0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            norm_q  <= 1'b0;
            acc_q   <= '0;
            m_q     <= '0;
            idx_q   <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            norm_q  <= norm_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready     = (state_q == StIdle) && !rst;
    assign bus.out_valid    = (state_q == StDone);
    assign bus.M            = m_q;
    assign bus.out_overflow = ovf_q;

endmodule

// File: tb/tb_multiplier_row_serial.sv
// Directed-vector and random scoreboard bench for the row-serial multiplier.
module tb_multiplier_row_serial;
    localparam int unsigned N  = 2;
    localparam int unsigned BL = 17;
    localparam int unsigned WL = 16;
    localparam int unsigned G  = WL + 2 + $clog2(2 * N);

    typedef logic [N-1:0][BL-1:0]   opnd_t;
    typedef logic [2*N-1:0][BL-1:0] res_t;
    typedef struct {
        opnd_t a;
        opnd_t b;
        logic  norm;
        res_t  m;
        logic  ovf;
        int    lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    multiplier_row_serial_if #(.NUM_ELEMENTS(N), .BIT_LEN(BL)) bus ();

    multiplier_row_serial #(
        .NUM_ELEMENTS(N),
        .BIT_LEN     (BL),
        .WORD_LEN    (WL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic opnd_t mk2(input logic [BL-1:0] l0, input logic [BL-1:0] l1);
        return {l1, l0};
    endfunction

    function automatic res_t mk4(input logic [BL-1:0] l0, input logic [BL-1:0] l1,
                                 input logic [BL-1:0] l2, input logic [BL-1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    // Redundant fold from column sums; normalised limbs from the exact product.
    task automatic ref_model(input opnd_t a, input opnd_t b, input logic norm,
                             output res_t em, output logic eovf);
        longint unsigned acc[2*N];
        longint unsigned p;
        longint unsigned mask;
        logic [127:0] total, exact, aval, bval;
        res_t red;
        mask  = (64'd1 << G) - 64'd1;
        total = '0;
        aval  = '0;
        bval  = '0;
        for (int c = 0; c < 2 * N; c++) acc[c] = 0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                p = 64'(a[j]) * 64'(b[k]);
                acc[j+k]   += p & 64'hFFFF;
                acc[j+k+1] += p >> 16;
            end
        end
        for (int c = 0; c < 2 * N; c++) acc[c] &= mask;
        red[0] = BL'(acc[0] & 64'hFFFF);
        for (int i = 1; i < 2 * N; i++) red[i] = BL'((acc[i] & 64'hFFFF) + (acc[i-1] >> 16));
        for (int i = 0; i < 2 * N; i++) total += 128'(red[i]) << (16 * i);
        for (int i = 0; i < N; i++) begin
            aval += 128'(a[i]) << (16 * i);
            bval += 128'(b[i]) << (16 * i);
        end
        exact = aval * bval;
        if (norm) begin
            for (int i = 0; i < 2 * N; i++) em[i] = BL'(exact[16*i +: 16]);
            eovf = (total[127:64] != '0);
        end else begin
            em   = red;
            eovf = 1'b0;
        end
    endtask

    // Starts at a negedge with the DUT idle; ends at a negedge after the output handshake.
    task automatic do_txn(input string tag, input opnd_t a, input opnd_t b, input logic norm,
                          input res_t em, input logic eovf, input int elat, input int stall,
                          input bit pulse);
        int lat;
        check({tag, " in_ready before accept"}, 128'(bus.in_ready), 128'(1));
        bus.A         = a;
        bus.B         = b;
        bus.normalize = norm;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        bus.A         = {BL'($urandom), BL'($urandom)};
        bus.B         = {BL'($urandom), BL'($urandom)};
        bus.normalize = 1'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            step();
            lat++;
        end
        check({tag, " latency"}, 128'(lat), 128'(elat));
        check({tag, " M"}, 128'(bus.M), 128'(em));
        check({tag, " out_overflow"}, 128'(bus.out_overflow), 128'(eovf));
        for (int s = 0; s < stall; s++) begin
            bus.in_valid  = pulse && (s % 2 == 0);
            bus.A         = {BL'($urandom), BL'($urandom)};
            bus.out_ready = 1'b0;
            step();
            check({tag, " stall out_valid"}, 128'(bus.out_valid), 128'(1));
            check({tag, " stall M"}, 128'(bus.M), 128'(em));
            check({tag, " stall out_overflow"}, 128'(bus.out_overflow), 128'(eovf));
            check({tag, " stall in_ready"}, 128'(bus.in_ready), 128'(0));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, " out_valid after handshake"}, 128'(bus.out_valid), 128'(0));
        check({tag, " in_ready after handshake"}, 128'(bus.in_ready), 128'(1));
    endtask

    initial begin
        vec_t  vecs[7];
        opnd_t ra, rb;
        logic  rn, rovf;
        res_t  rm;

        vecs[0] = '{mk2(3, 0), mk2(5, 0), 1'b0, mk4(15, 0, 0, 0), 1'b0, 3};
        vecs[1] = '{mk2('hFFFF, 'hFFFF), mk2('hFFFF, 'hFFFF), 1'b1,
                    mk4('h1, 'h0, 'hFFFE, 'hFFFF), 1'b0, 7};
        vecs[2] = '{mk2('hFFFF, 'hFFFF), mk2('hFFFF, 'hFFFF), 1'b0,
                    mk4('h1, 'h0, 'hFFFE, 'hFFFF), 1'b0, 3};
        vecs[3] = '{mk2('h1FFFF, 'h1FFFF), mk2('h1FFFF, 'h1FFFF), 1'b1,
                    mk4('h1, 'hFFFE, 'hFFFC, 'h3), 1'b1, 7};
        vecs[4] = '{mk2('h1FFFF, 'h1FFFF), mk2('h1FFFF, 'h1FFFF), 1'b0,
                    mk4('h1, 'hFFFE, 'hFFFC, 'h10003), 1'b0, 3};
        vecs[5] = '{mk2(2, 1), mk2(3, 4), 1'b1, mk4(6, 11, 4, 0), 1'b0, 7};
        vecs[6] = '{mk2('hFFFF, 'h1FFFF), mk2(1, 1), 1'b0,
                    mk4('hFFFF, 'hFFFE, 'h1, 'h2), 1'b0, 3};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.normalize = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset out_valid", 128'(bus.out_valid), 128'(0));
        check("reset out_overflow", 128'(bus.out_overflow), 128'(0));
        check("reset M", 128'(bus.M), 128'(0));
        check("reset in_ready low during rst", 128'(bus.in_ready), 128'(0));
        rst = 1'b0;
        #1;
        check("in_ready after reset release", 128'(bus.in_ready), 128'(1));
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            do_txn($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].norm,
                   vecs[v].m, vecs[v].ovf, vecs[v].lat, 0, 1'b0);
        end

        // Output held through a 5-cycle stall while in_valid pulses.
        do_txn("hold", vecs[3].a, vecs[3].b, 1'b1, vecs[3].m, 1'b1, 7, 5, 1'b1);
        repeat (3) begin
            step();
            check("hold no capture", 128'(bus.out_valid), 128'(0));
        end

        // Reset during MUL row 1 aborts without output.
        bus.A         = mk2(3, 0);
        bus.B         = mk2(5, 0);
        bus.normalize = 1'b0;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("abort out_valid", 128'(bus.out_valid), 128'(0));
        check("abort in_ready", 128'(bus.in_ready), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort in_ready after release", 128'(bus.in_ready), 128'(1));
        @(negedge clk);
        check("abort no output", 128'(bus.out_valid), 128'(0));
        do_txn("after_abort", mk2(3, 0), mk2(5, 0), 1'b0, mk4(15, 0, 0, 0), 1'b0, 3, 0, 1'b0);

        for (int t = 0; t < 200; t++) begin
            ra = {BL'($urandom), BL'($urandom)};
            rb = {BL'($urandom), BL'($urandom)};
            rn = 1'($urandom);
            ref_model(ra, rb, rn, rm, rovf);
            do_txn($sformatf("rand%0d", t), ra, rb, rn, rm, rovf,
                   rn ? int'(3 * N + 1) : int'(N + 1), int'($urandom_range(0, 3)),
                   1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multiplier_row_serial.md
Name: multiplier_row_serial

Overview:
- Sequential, parametrised successor to the combinational limb-array multiplier.
- Multiplies two NUM_ELEMENTS-limb redundant operands one B-limb row per cycle. Uses NUM_ELEMENTS DSP multipliers instead of NUM_ELEMENTS^2.
- Accumulates into a column accumulator and emits 2*NUM_ELEMENTS output limbs, either in redundant form or fully carry-normalised (new mode).
- Sits between operand producers and modular-reduction logic, with valid/ready handshakes on both sides.

Parameters:
- NUM_ELEMENTS, 17, limbs per operand (>=2).
- BIT_LEN, 17, limb width (redundant, >= WORD_LEN+1).
- WORD_LEN, 16, radix bits per limb.
- GRID_PP_BIT (derived), WORD_LEN+2+$clog2(2*NUM_ELEMENTS), accumulator column width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- normalize  in  1  mode, sampled with operands: 0 = redundant output, 1 = normalised output
- A  in  [BIT_LEN-1:0] x NUM_ELEMENTS  multiplicand limbs, little-endian
- B  in  [BIT_LEN-1:0] x NUM_ELEMENTS  multiplier limbs, little-endian
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- M  out  [BIT_LEN-1:0] x 2*NUM_ELEMENTS  product limbs
- out_overflow  out  1  normalised carry-out of the top limb was nonzero (mode 1 only)

Behaviour:
- Reset: asynchronous, active-high. state=IDLE; out_valid=0; out_overflow=0; all M limbs=0; accumulator, row counter and carry register cleared. in_ready = (state==IDLE) && !rst.
- Reset mid-operation aborts the transaction with no output. in_ready=1 in the first cycle after deassertion.
- FSM states: IDLE, MUL, FOLD, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: register A, B and normalize; clear the accumulator; row=0; go to MUL.
- MUL (NUM_ELEMENTS cycles):
  - Row k: p[j] = A[j]*B[k], full 2*BIT_LEN bits, for every j.
  - acc[j+k] += zero-extended p[j][WORD_LEN-1:0].
  - acc[j+k+1] += p[j][2*BIT_LEN-1:WORD_LEN].
  - All additions are modulo 2^GRID_PP_BIT; GRID_PP_BIT is sized so no column overflows for legal BIT_LEN inputs.
  - When k==NUM_ELEMENTS-1, go to FOLD.
- FOLD (1 cycle):
  - M[0] = acc[0][WORD_LEN-1:0].
  - M[i] = acc[i][WORD_LEN-1:0] + acc[i-1][GRID_PP_BIT-1:WORD_LEN], truncated to BIT_LEN.
  - Go to NORM if normalize=1, else go to DONE.
- NORM (2*NUM_ELEMENTS cycles, column c = 0..2N-1):
  - s = M[c] + carry.
  - M[c] = zero-extended s[WORD_LEN-1:0]; carry = s >> WORD_LEN.
  - After the last column: out_overflow = (carry != 0); go to DONE.
- DONE:
  - out_valid=1. M and out_overflow are held stable while out_ready=0.
  - in_ready=0; in_valid is ignored.
  - On out_ready: out_valid drops at the next edge; go to IDLE.
  - The next operands can be accepted one cycle after the output handshake.
- Latency, from the accepting edge e0: out_valid first high after edge e0+NUM_ELEMENTS+1 (mode 0) or e0+3*NUM_ELEMENTS+1 (mode 1).
- Mode 0 results are bit-identical to the combinational predecessor for the same A and B.
- out_overflow is always 0 in mode 0.
- A and B are not required to stay stable after the accept edge.

Decomposition:
- Package multiplier_pkg:
  - state enum: IDLE, MUL, FOLD, NORM, DONE.
  - GRID_PP_BIT function.
  - Carry-register width (BIT_LEN-WORD_LEN+1).
- Sub-module: reuse the existing dsp_multiplier, instantiated NUM_ELEMENTS times (one row of products per cycle).
- The column accumulator and FSM stay in the top module.

Test Plan:
Bench parameters: NUM_ELEMENTS=2, BIT_LEN=17, WORD_LEN=16.
1. A={3,0}, B={5,0}, normalize=0 -> M={15,0,0,0}; out_valid first high after edge e0+3.
2. A={0xFFFF,0xFFFF}, B={0xFFFF,0xFFFF}, normalize=1 -> M={0x0001,0x0000,0xFFFE,0xFFFF}, out_overflow=0, out_valid after edge e0+7.
3. A=B={0x1FFFF,0x1FFFF}, normalize=1 -> out_overflow=1 and limbs equal the low 64 bits of the exact product. Same operands with normalize=0 -> M matches the combinational reference model, out_overflow=0.
4. out_ready held low 5 cycles in DONE while in_valid pulses -> M, out_valid and out_overflow stable, in_ready=0, no operand capture.
5. rst asserted during MUL row 1 -> out_valid=0 immediately; in_ready=1 the cycle after deassertion; the following case-1 transaction yields M={15,0,0,0}.
6. 200 random back-to-back transactions, random mode, random out_ready -> every result matches the scoreboard (exact product, plus the redundant fold for mode 0); no transaction lost or duplicated.
